// File: rtl/act_lut_sequencer.sv
// Walks N pre-activations through one shared activation LUT and linearly
// interpolates between adjacent entries, writing one result every three cycles.
module act_lut_sequencer #(
  parameter int N_NEURONS = 4,
  parameter int IN_W      = 8,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int FRAC_W    = IN_W - ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_NEURONS*IN_W-1:0]     in_vec,
  output logic [ADDR_W-1:0]             lut_address,
  input  logic [DATA_W-1:0]             lut_base,
  input  logic [DATA_W-1:0]             lut_next,
  output logic                          busy,
  output logic                          done,
  output logic [N_NEURONS*DATA_W-1:0]   out_vec
);

  localparam int IDX_W  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int PROD_W = DATA_W + FRAC_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MULT,
    S_WB,
    S_DONE
  } state_t;

  state_t                        state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [N_NEURONS*IN_W-1:0]     x_q;
  logic [ADDR_W-1:0]             addr_q;
  logic [DATA_W-1:0]             base_q;
  logic [DATA_W-1:0]             next_q;
  logic [FRAC_W-1:0]             frac_q;
  logic [PROD_W-1:0]             prod_q;
  logic                          busy_q;
  logic                          done_q;
  logic [N_NEURONS*DATA_W-1:0]   out_q;

  logic [FRAC_W-1:0]             curFrac_d;
  logic [ADDR_W-1:0]             nextAddr_d;
  logic [IDX_W-1:0]              nextIdx_d;
  logic [DATA_W:0]               diff_d;
  logic [PROD_W-1:0]             prod_d;
  logic [PROD_W-1:0]             shf_d;
  logic [DATA_W+1:0]             sum_d;
  logic [DATA_W-1:0]             y_d;

  assign nextIdx_d = idx_q + 1'b1;

  // Element selection by constant slices so every index stays in range.
  always_comb begin
    curFrac_d  = '0;
    nextAddr_d = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (k == int'(idx_q))
        curFrac_d = x_q[k*IN_W +: FRAC_W];
      if (k == int'(nextIdx_d))
        nextAddr_d = x_q[k*IN_W + FRAC_W +: ADDR_W];
    end
  end

  // Two's-complement arithmetic on raw bits; frac is zero-extended as unsigned.
  assign diff_d = {next_q[DATA_W-1], next_q} - {base_q[DATA_W-1], base_q};
  assign prod_d = {{FRAC_W{diff_d[DATA_W]}}, diff_d} * {{(DATA_W+1){1'b0}}, frac_q};
  assign shf_d  = $unsigned($signed(prod_q) >>> FRAC_W);
  assign sum_d  = {{2{base_q[DATA_W-1]}}, base_q} + {shf_d[DATA_W], shf_d[DATA_W:0]};

  always_comb begin
    y_d = sum_d[DATA_W-1:0];
    if (sum_d[DATA_W+1] && (sum_d[DATA_W:DATA_W-1] != 2'b11))
      y_d = {1'b1, {(DATA_W-1){1'b0}}};
    else if (!sum_d[DATA_W+1] && (sum_d[DATA_W:DATA_W-1] != 2'b00))
      y_d = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      next_q  <= '0;
      frac_q  <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= in_vec;
            idx_q   <= '0;
            addr_q  <= in_vec[FRAC_W +: ADDR_W];
            busy_q  <= 1'b1;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          base_q  <= lut_base;
          next_q  <= lut_next;
          frac_q  <= curFrac_d;
          state_q <= S_MULT;
        end
        S_MULT: begin
          prod_q  <= prod_d;
          state_q <= S_WB;
        end
        S_WB: begin
          for (int k = 0; k < N_NEURONS; k++) begin
            if (k == int'(idx_q))
              out_q[k*DATA_W +: DATA_W] <= y_d;
          end
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= nextIdx_d;
            addr_q  <= nextAddr_d;
            state_q <= S_LOOKUP;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign lut_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_vec     = out_q;

endmodule

// File: tb/tb_act_lut_sequencer.sv
// Self-checking bench for act_lut_sequencer: a cycle-offset behavioural model
// plus directed literal checks for interpolation, edge entries, timing and reset.
module tb_act_lut_sequencer;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] inVec;
  logic [3:0]  lutAddress;
  logic [7:0]  lutBase;
  logic [7:0]  lutNext;
  logic        busy;
  logic        done;
  logic [31:0] outVec;

  logic        start1;
  logic [7:0]  inVec1;
  logic [3:0]  lutAddress1;
  logic [7:0]  lutBase1;
  logic [7:0]  lutNext1;
  logic        busy1;
  logic        done1;
  logic [7:0]  outVec1;

  logic [7:0]  lut [16];

  int checks = 0;
  int errors = 0;
  logic checkEn = 1'b0;

  // Behavioural LUT: address 7 clamps, address 15 wraps to entry 0.
  assign lutBase  = lut[lutAddress];
  assign lutNext  = (lutAddress == 4'd7) ? lut[7] : lut[lutAddress + 4'd1];
  assign lutBase1 = lut[lutAddress1];
  assign lutNext1 = (lutAddress1 == 4'd7) ? lut[7] : lut[lutAddress1 + 4'd1];

  act_lut_sequencer #(.N_NEURONS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(inVec),
    .lut_address(lutAddress), .lut_base(lutBase), .lut_next(lutNext),
    .busy(busy), .done(done), .out_vec(outVec)
  );

  act_lut_sequencer #(.N_NEURONS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_vec(inVec1),
    .lut_address(lutAddress1), .lut_base(lutBase1), .lut_next(lutNext1),
    .busy(busy1), .done(done1), .out_vec(outVec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interpolated value from plain integer arithmetic with explicit floor division.
  function automatic int interp(input logic [7:0] x);
    int a, f, b, n, p, q, y;
    logic signed [7:0] tmp;
    a = int'(x[7:4]);
    f = int'(x[3:0]);
    tmp = lut[a];
    b = tmp;
    tmp = (a == 7) ? lut[7] : lut[(a + 1) % 16];
    n = tmp;
    p = (n - b) * f;
    q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    y = b + q;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: tracks edges since acceptance rather than FSM states.
  bit          modelRunning;
  int          modelT;
  logic [31:0] modelX;
  int          expRes [N];
  logic [31:0] expOut;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      modelRunning = 1'b0;
      modelT       = 0;
      expOut       = '0;
      modelX       = '0;
    end else if (modelRunning) begin
      modelT++;
      if ((modelT % 3 == 0) && (modelT <= 3 * N))
        expOut[(modelT / 3 - 1) * 8 +: 8] = 8'(expRes[modelT / 3 - 1]);
      if (modelT == 3 * N + 1)
        modelRunning = 1'b0;
    end else if (start) begin
      modelRunning = 1'b1;
      modelT       = 0;
      modelX       = inVec;
      for (int k = 0; k < N; k++)
        expRes[k] = interp(inVec[k*8 +: 8]);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn && rst) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, modelRunning && (modelT < 3 * N)});
      checkOutput("done", {31'd0, done}, {31'd0, modelRunning && (modelT == 3 * N)});
      checkOutput("outVec", outVec, expOut);
      if (modelRunning && (modelT < 3 * N) && (modelT % 3 == 0))
        checkOutput("lutAddress", {28'd0, lutAddress},
                    {28'd0, modelX[(modelT / 3) * 8 + 4 +: 4]});
    end
  end

  task automatic applyStimulus(input logic [31:0] vec);
    @(negedge clk);
    inVec = vec;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge of cycle 1; returns the cycle where done is seen.
  task automatic waitDone(output int doneCycle, output int busyCount);
    doneCycle = 1;
    busyCount = 0;
    while (doneCycle < 60) begin
      if (busy) busyCount++;
      if (done) break;
      @(negedge clk);
      doneCycle++;
    end
    checkOutput("doneSeen", {31'd0, done}, 32'd1);
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((busy || done) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idleReached", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int dc, bc, lastDone, c;
    logic prevBusy;
    rst = 1'b0;
    start = 1'b0;
    inVec = '0;
    start1 = 1'b0;
    inVec1 = '0;
    for (int i = 0; i < 16; i++) lut[i] = 8'(i * 16);

    repeat (2) @(negedge clk);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetOut", outVec, 32'd0);
    checkOutput("resetAddr", {28'd0, lutAddress}, 32'd0);
    rst = 1'b1;
    checkEn = 1'b1;

    $display("[TB] interior interpolation");
    applyStimulus({8'h48, 8'h03, 8'h10, 8'h25});
    waitDone(dc, bc);
    checkOutput("interiorDoneCycle", dc, 32'd13);
    checkOutput("interiorBusyCycles", bc, 32'd12);
    checkOutput("interiorOut", outVec, {8'd72, 8'd3, 8'd16, 8'd37});
    waitIdle();

    $display("[TB] edge entries");
    applyStimulus({8'hFF, 8'h80, 8'hF8, 8'h7F});
    waitDone(dc, bc);
    checkOutput("edgeOut", outVec, {8'hFF, 8'h80, 8'hF8, 8'd112});
    waitIdle();

    $display("[TB] steep segment");
    lut[3] = 8'd127;
    lut[4] = 8'h80;
    applyStimulus({8'h00, 8'h00, 8'h00, 8'h3F});
    waitDone(dc, bc);
    checkOutput("steepOut", {24'd0, outVec[7:0]}, {24'd0, 8'h8F});
    waitIdle();
    lut[3] = 8'd48;
    lut[4] = 8'd64;

    $display("[TB] reset mid-run");
    applyStimulus({8'h11, 8'h22, 8'h33, 8'h44});
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortDone", {31'd0, done}, 32'd0);
    checkOutput("abortOut", outVec, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus({8'h48, 8'h03, 8'h10, 8'h25});
    waitDone(dc, bc);
    checkOutput("afterAbortOut", outVec, {8'd72, 8'd3, 8'd16, 8'd37});
    waitIdle();

    $display("[TB] start held high");
    lastDone = -1;
    prevBusy = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) lastDone = i;
      if (busy && !prevBusy && lastDone >= 0)
        checkOutput("doneToLookupGap", i - lastDone, 32'd2);
      prevBusy = busy;
      inVec = $urandom;
    end
    start = 1'b0;
    waitIdle();

    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++) lut[i] = 8'($urandom);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      start = ($urandom_range(3) == 0);
      inVec = $urandom;
    end
    start = 1'b0;
    @(negedge clk);
    waitIdle();
    for (int i = 0; i < 16; i++) lut[i] = 8'(i * 16);

    $display("[TB] single element");
    @(negedge clk);
    inVec1 = 8'h25;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    c = 1;
    while (!done1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput("singleDoneCycle", c, 32'd4);
    checkOutput("singleOut", {24'd0, outVec1}, 32'd37);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
